// File: rtl/seg7_pkg.sv
// seg7_pkg: constants and helpers shared by the 7-segment scan multiplexer.
// Segment patterns are written in a..g order (bit 6 = a ... bit 0 = g), 1 = lit.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Hex digit to segment pattern, a..g from MSB to LSB, active-high.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

    // Split a 0..31 value into {tens[1:0], units[3:0]}. The units are formed
    // modulo 16, which is exact because the remainder is always below 10.
    function automatic logic [5:0] bin_to_dec(input logic [4:0] value);
        logic [1:0] tens;
        logic [3:0] offset;
        if (value >= 5'd30) begin
            tens   = 2'd3;
            offset = 4'd14;  // 30 mod 16
        end else if (value >= 5'd20) begin
            tens   = 2'd2;
            offset = 4'd4;   // 20 mod 16
        end else if (value >= 5'd10) begin
            tens   = 2'd1;
            offset = 4'd10;
        end else begin
            tens   = 2'd0;
            offset = 4'd0;
        end
        return {tens, value[3:0] - offset};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex to 7-segment decode with a blank override.
// Output is active-high with segments[0] = a ... segments[6] = g.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] segments
);

    logic [6:0] pattern;

    assign pattern = HEX_SEG_TABLE[digit];

    // The table is stored a..g from MSB down, so reverse it onto seg[0]=a.
    for (genvar gi = 0; gi < 7; gi++) begin : g_seg
        assign segments[gi] = ~blank & pattern[6-gi];
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: four-digit multiplexed 7-segment driver for an adder demo.
// Digits 3/2 show op_a/op_b in hex, digits 1/0 show sum in decimal.
// scan_clk is synchronised and edge-detected into scan_tick; each tick
// advances the digit index with a one-cycle all-off gap against ghosting.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks the tens digit
// when sum < 10.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int COMMON_ANODE = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       scan_clk,
    input  logic [3:0] op_a,
    input  logic [3:0] op_b,
    input  logic [4:0] sum,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam logic OFF_LEVEL = (COMMON_ANODE != 0) ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0]  sync_reg;
    logic                    edge_reg;
    logic                    tick_reg;
    logic [1:0]              index_reg;
    logic                    armed_reg;
    logic [3:0]              frame_a_reg;
    logic [3:0]              frame_b_reg;
    logic [4:0]              frame_sum_reg;
    scan_state_t             state_reg;
    scan_state_t             state_next;
    logic [6:0]              seg_reg;
    logic [6:0]              seg_next;
    logic [3:0]              an_reg;
    logic [3:0]              an_next;
    logic                    dp_reg;
    logic [5:0]              dec_digits;
    logic [3:0]              digit_value;
    logic                    digit_blank;
    logic [6:0]              digit_lit;
    logic [NUM_DIGITS-1:0]   digit_sel;

    // Synchroniser chain: scan_clk is sampled as data only.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            always_ff @(posedge clk_in or negedge rst_n) begin
                if (!rst_n) sync_reg[gi] <= 1'b0;
                else        sync_reg[gi] <= scan_clk;
            end
        end else begin : g_rest
            always_ff @(posedge clk_in or negedge rst_n) begin
                if (!rst_n) sync_reg[gi] <= 1'b0;
                else        sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    end

    // Rising-edge detect on the last stage, registered into a one-cycle tick.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            edge_reg <= 1'b0;
            tick_reg <= 1'b0;
        end else begin
            edge_reg <= sync_reg[SYNC_STAGES-1];
            tick_reg <= sync_reg[SYNC_STAGES-1] & ~edge_reg;
        end
    end

    // Digit index and frame snapshot; the snapshot is taken only on the 3->0
    // wrap so every digit of a frame comes from the same input sample.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            index_reg     <= 2'd3;
            armed_reg     <= 1'b0;
            frame_a_reg   <= 4'd0;
            frame_b_reg   <= 4'd0;
            frame_sum_reg <= 5'd0;
        end else if (tick_reg) begin
            index_reg <= index_reg + 2'd1;
            armed_reg <= 1'b1;
            if (index_reg == 2'd3) begin
                frame_a_reg   <= op_a;
                frame_b_reg   <= op_b;
                frame_sum_reg <= sum;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state_reg <= BLANK;
        else        state_reg <= state_next;
    end

    // Next state: every tick forces one blank cycle; nothing is shown until
    // the first tick after reset has been processed.
    always_comb begin
        state_next = state_reg;
        if (tick_reg) begin
            state_next = BLANK;
        end else if (state_reg == BLANK && armed_reg) begin
            state_next = SHOW;
        end
    end

    // Digit content for the current index.
    assign dec_digits = bin_to_dec(frame_sum_reg);

    always_comb begin
        digit_value = 4'd0;
        digit_blank = 1'b0;
        case (index_reg)
            2'd0: digit_value = dec_digits[3:0];
            2'd1: begin
                digit_value = {2'b00, dec_digits[5:4]};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                digit_blank = (dec_digits[5:4] == 2'd0);
`else
                digit_blank = 1'b0;
`endif
            end
            2'd2: digit_value = frame_b_reg;
            default: digit_value = frame_a_reg;
        endcase
    end

    seg7_decode u_decode (
        .digit    (digit_value),
        .blank    (digit_blank),
        .segments (digit_lit)
    );

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
        assign digit_sel[gi] = (index_reg == 2'(gi));
    end

    // Output decode from the next state, so the registered pins follow the FSM.
    always_comb begin
        seg_next = {7{OFF_LEVEL}};
        an_next  = {NUM_DIGITS{OFF_LEVEL}};
        if (state_next == SHOW) begin
            seg_next = digit_lit ^ {7{OFF_LEVEL}};
            an_next  = digit_sel ^ {NUM_DIGITS{OFF_LEVEL}};
        end
    end

    // Output registers; reset drops them to the inactive level at once.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg <= {7{OFF_LEVEL}};
            an_reg  <= {NUM_DIGITS{OFF_LEVEL}};
            dp_reg  <= OFF_LEVEL;
        end else begin
            seg_reg <= seg_next;
            an_reg  <= an_next;
            dp_reg  <= OFF_LEVEL;
        end
    end

    assign seg = seg_reg;
    assign an  = an_reg;
    assign dp  = dp_reg;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed bench for seg7_scan_mux at COMMON_ANODE=1,
// SYNC_STAGES=2. Expected segment patterns are hand-written in a..g order.
module tb_seg7_scan_mux;

    logic       clk_in;
    logic       rst_n;
    logic       scan_clk;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [4:0] sum;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] PA = 7'b1110111;
    localparam logic [6:0] PF = 7'b1000111;
    localparam logic [6:0] PX = 7'b0000000;  // no segment lit

    seg7_scan_mux #(
        .COMMON_ANODE (1),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .scan_clk (scan_clk),
        .op_a     (op_a),
        .op_b     (op_b),
        .sum      (sum),
        .seg      (seg),
        .an       (an),
        .dp       (dp)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // a..g pattern (1 = lit) to active-low pins with seg[0] = a.
    function automatic logic [6:0] pins(input logic [6:0] p);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = ~p[6-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One scan_clk pulse: the previous digit must hold for 3 cycles, the
    // anodes go dark for exactly one cycle, then the new digit appears.
    task automatic scan_step(input string tag, input logic [3:0] prev_an,
                             input logic [3:0] exp_an, input logic [6:0] exp_pat);
        scan_clk = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_in);
            check($sformatf("%s_lat%0d", tag, i), {4'h0, an}, {4'h0, prev_an});
        end
        @(negedge clk_in);
        check({tag, "_gap"}, {4'h0, an}, 8'h0F);
        @(negedge clk_in);
        check({tag, "_an"}, {4'h0, an}, {4'h0, exp_an});
        check({tag, "_seg"}, {1'b0, seg}, {1'b0, pins(exp_pat)});
        check({tag, "_dp"}, {7'h0, dp}, 8'h01);
        scan_clk = 1'b0;
        repeat (4) @(negedge clk_in);
        check({tag, "_hold"}, {1'b0, seg}, {1'b0, pins(exp_pat)});
        $display("step %s: an=%b seg=%b", tag, an, seg);
    endtask

    initial begin
        logic [6:0] tens_small;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        tens_small = PX;
`else
        tens_small = P0;
`endif
        rst_n    = 1'b0;
        scan_clk = 1'b0;
        op_a     = 4'hA;
        op_b     = 4'h3;
        sum      = 5'd27;

        repeat (3) @(negedge clk_in);
        check("rst_seg", {1'b0, seg}, 8'h7F);
        check("rst_an", {4'h0, an}, 8'h0F);
        check("rst_dp", {7'h0, dp}, 8'h01);
        rst_n = 1'b1;
        repeat (6) @(negedge clk_in);
        check("idle_seg", {1'b0, seg}, 8'h7F);
        check("idle_an", {4'h0, an}, 8'h0F);

        // Frame 1: A, 3, 27
        scan_step("f1_d0", 4'hF, 4'b1110, P7);
        scan_step("f1_d1", 4'b1110, 4'b1101, P2);
        scan_step("f1_d2", 4'b1101, 4'b1011, P3);
        scan_step("f1_d3", 4'b1011, 4'b0111, PA);

        // Frame 2: sum 12, then inputs change while index is 1
        sum = 5'd12;
        scan_step("f2_d0", 4'b0111, 4'b1110, P2);
        scan_step("f2_d1", 4'b1110, 4'b1101, P1);
        sum  = 5'd30;
        op_a = 4'h5;
        scan_step("f2_d2", 4'b1101, 4'b1011, P3);
        scan_step("f2_d3", 4'b1011, 4'b0111, PA);

        // Frame 3: new snapshot 5, 3, 30
        scan_step("f3_d0", 4'b0111, 4'b1110, P0);
        scan_step("f3_d1", 4'b1110, 4'b1101, P3);
        scan_step("f3_d2", 4'b1101, 4'b1011, P3);
        scan_step("f3_d3", 4'b1011, 4'b0111, P5);

        // Frame 4: sum below ten, tens digit
        sum = 5'd5;
        scan_step("f4_d0", 4'b0111, 4'b1110, P5);
        scan_step("f4_d1", 4'b1110, 4'b1101, tens_small);
        scan_step("f4_d2", 4'b1101, 4'b1011, P3);

        // Asynchronous reset while digit 2 is shown
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_an", {4'h0, an}, 8'h0F);
        check("arst_seg", {1'b0, seg}, 8'h7F);
        op_a = 4'h1;
        op_b = 4'hF;
        sum  = 5'd31;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_in);
        check("post_rst_an", {4'h0, an}, 8'h0F);

        // Fresh frame after reset: 1, F, 31
        scan_step("f5_d0", 4'hF, 4'b1110, P1);
        scan_step("f5_d1", 4'b1110, 4'b1101, P3);
        scan_step("f5_d2", 4'b1101, 4'b1011, PF);
        scan_step("f5_d3", 4'b1011, 4'b0111, P1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
